// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants and types used by dispatch,
// reservation stations and the register status table.
package tomasulo_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int TAG_W     = 2;
    localparam int CNT_W     = 4;
    localparam int NUM_RS    = 4;

    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam tag_t RS_ADD1 = tag_t'(0);
    localparam tag_t RS_ADD2 = tag_t'(1);
    localparam tag_t RS_MUL1 = tag_t'(2);
    localparam tag_t RS_MUL2 = tag_t'(3);

    typedef struct packed {
        logic busy;
        tag_t qi;
    } rs_entry_t;

endpackage

// File: rtl/register_status_table_if.sv
// Dispatch/CDB side bundle of the register status table.
// The master drives rename, CDB, flush and lookup addresses.
interface register_status_table_if;
    import tomasulo_pkg::*;

    logic     Issue_En;
    reg_idx_t Issue_Rd;
    tag_t     Issue_Tag;
    logic     Cdb_Valid;
    tag_t     Cdb_Tag;
    logic     Flush;
    reg_idx_t Rd_Addr_A;
    reg_idx_t Rd_Addr_B;
    logic     Busy_A;
    logic     Busy_B;
    tag_t     Qi_A;
    tag_t     Qi_B;
    cnt_t     Pending_Count;
    logic     All_Clear;

    modport master (
        output Issue_En, Issue_Rd, Issue_Tag,
        output Cdb_Valid, Cdb_Tag, Flush,
        output Rd_Addr_A, Rd_Addr_B,
        input  Busy_A, Busy_B, Qi_A, Qi_B,
        input  Pending_Count, All_Clear
    );

    modport slave (
        input  Issue_En, Issue_Rd, Issue_Tag,
        input  Cdb_Valid, Cdb_Tag, Flush,
        input  Rd_Addr_A, Rd_Addr_B,
        output Busy_A, Busy_B, Qi_A, Qi_B,
        output Pending_Count, All_Clear
    );

endinterface

// File: rtl/register_status_entry.sv
// One busy/Qi pair: flush beats issue, issue beats CDB clear.
module register_status_entry
    import tomasulo_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      issue_we_i,
    input  tag_t      issue_tag_i,
    input  logic      cdb_valid_i,
    input  tag_t      cdb_tag_i,
    output rs_entry_t entry_d_o,
    output rs_entry_t entry_q_o
);

    rs_entry_t entry_q;
    rs_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (issue_we_i) begin
            entry_d.busy = 1'b1;
            entry_d.qi   = issue_tag_i;
        end else if (cdb_valid_i && entry_q.busy &&
                     entry_q.qi == cdb_tag_i) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_d_o = entry_d;
    assign entry_q_o = entry_q;

endmodule

// File: rtl/register_status_table.sv
// Tomasulo Qi table: rename decode, CDB-bypassed operand
// lookups and a registered count of busy entries.
module register_status_table
    import tomasulo_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    register_status_table_if.slave bus
);

    rs_entry_t           ent_q [NUM_REGS];
    rs_entry_t           ent_d [NUM_REGS];
    logic [NUM_REGS-1:0] issue_we;
    rs_entry_t           hit_a;
    rs_entry_t           hit_b;
    cnt_t                cnt_q;
    cnt_t                cnt_d;
    logic                clr_q;
    logic                clr_d;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            issue_we[r] = bus.Issue_En &&
                (bus.Issue_Rd == REG_IDX_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
        register_status_entry u_ent (
            .clk_i       (Clock),
            .rst_i       (Reset),
            .flush_i     (bus.Flush),
            .issue_we_i  (issue_we[g]),
            .issue_tag_i (bus.Issue_Tag),
            .cdb_valid_i (bus.Cdb_Valid),
            .cdb_tag_i   (bus.Cdb_Tag),
            .entry_d_o   (ent_d[g]),
            .entry_q_o   (ent_q[g])
        );
    end

    // Unmatched addresses fall through to an idle entry;
    // a live CDB broadcast hides the tag it is retiring.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.Rd_Addr_A == REG_IDX_W'(r)) hit_a = ent_q[r];
            if (bus.Rd_Addr_B == REG_IDX_W'(r)) hit_b = ent_q[r];
        end
        if (bus.Cdb_Valid && hit_a.busy &&
            hit_a.qi == bus.Cdb_Tag) begin
            hit_a = '0;
        end
        if (bus.Cdb_Valid && hit_b.busy &&
            hit_b.qi == bus.Cdb_Tag) begin
            hit_b = '0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + CNT_W'(ent_d[r].busy);
        end
        clr_d = (cnt_d == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            clr_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            clr_q <= clr_d;
        end
    end

    assign bus.Busy_A        = hit_a.busy;
    assign bus.Qi_A          = hit_a.qi;
    assign bus.Busy_B        = hit_b.busy;
    assign bus.Qi_B          = hit_b.qi;
    assign bus.Pending_Count = cnt_q;
    assign bus.All_Clear     = clr_q;

endmodule

// File: tb/tb_register_status_table.sv
// Directed and random checks of the register status table
// against a per-register busy/tag reference model.
module tb_register_status_table;
    import tomasulo_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic       m_busy [NUM_REGS];
    logic [1:0] m_qi   [NUM_REGS];

    logic       o_ba;
    logic       o_bb;
    logic [1:0] o_qa;
    logic [1:0] o_qb;
    logic [3:0] o_cnt;
    logic       o_clr;

    register_status_table_if bus ();

    register_status_table dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Operand view: stored state, hidden if the CDB is retiring it.
    function automatic logic [2:0] m_look(input logic [2:0] a,
                                          input logic cv,
                                          input logic [1:0] ct);
        if (int'(a) >= NUM_REGS) return 3'b000;
        if (!m_busy[a]) return 3'b000;
        if (cv && m_qi[a] == ct) return 3'b000;
        return {1'b1, m_qi[a]};
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_busy[r] = 1'b0;
            m_qi[r]   = 2'd0;
        end
    endtask

    task automatic step(input logic ie, input logic [2:0] rd,
                        input logic [1:0] it, input logic cv,
                        input logic [1:0] ct, input logic fl,
                        input logic [2:0] a, input logic [2:0] b);
        logic [2:0] ea;
        logic [2:0] eb;
        @(negedge clk);
        bus.Issue_En  = ie;
        bus.Issue_Rd  = rd;
        bus.Issue_Tag = it;
        bus.Cdb_Valid = cv;
        bus.Cdb_Tag   = ct;
        bus.Flush     = fl;
        bus.Rd_Addr_A = a;
        bus.Rd_Addr_B = b;
        #1;
        ea = m_look(a, cv, ct);
        eb = m_look(b, cv, ct);
        o_ba  = bus.Busy_A;
        o_qa  = bus.Qi_A;
        o_bb  = bus.Busy_B;
        o_qb  = bus.Qi_B;
        o_cnt = bus.Pending_Count;
        o_clr = bus.All_Clear;
        chk("busy_a", 32'(o_ba), 32'(ea[2]));
        chk("qi_a", 32'(o_qa), 32'(ea[1:0]));
        chk("busy_b", 32'(o_bb), 32'(eb[2]));
        chk("qi_b", 32'(o_qb), 32'(eb[1:0]));
        chk("count", 32'(o_cnt), 32'(m_count()));
        chk("all_clear", 32'(o_clr), 32'(m_count() == 0));
        @(posedge clk);
        if (fl) begin
            m_clear();
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cv && m_busy[r] && m_qi[r] == ct) begin
                    m_busy[r] = 1'b0;
                    m_qi[r]   = 2'd0;
                end
            end
            if (ie && int'(rd) < NUM_REGS) begin
                m_busy[rd] = 1'b1;
                m_qi[rd]   = it;
            end
        end
    endtask

    task automatic idle(input logic [2:0] a, input logic [2:0] b);
        step(0, 0, 0, 0, 0, 0, a, b);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_clear();
        rst = 1'b1;
        bus.Issue_En  = 1'b0;
        bus.Issue_Rd  = '0;
        bus.Issue_Tag = '0;
        bus.Cdb_Valid = 1'b0;
        bus.Cdb_Tag   = '0;
        bus.Flush     = 1'b0;
        bus.Rd_Addr_A = 3'd2;
        bus.Rd_Addr_B = 3'd7;
        #2;
        chk("rst_busy_a", 32'(bus.Busy_A), 32'd0);
        chk("rst_qi_a", 32'(bus.Qi_A), 32'd0);
        chk("rst_busy_b", 32'(bus.Busy_B), 32'd0);
        chk("rst_count", 32'(bus.Pending_Count), 32'd0);
        chk("rst_clear", 32'(bus.All_Clear), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // rename R2 to tag 1; visible one cycle later
        step(1, 3'd2, RS_ADD2, 0, 0, 0, 3'd2, 3'd0);
        chk("issue_no_bypass", 32'(o_ba), 32'd0);
        idle(3'd2, 3'd0);
        chk("issue_busy", 32'(o_ba), 32'd1);
        chk("issue_qi", 32'(o_qa), 32'd1);
        chk("issue_cnt", 32'(o_cnt), 32'd1);
        chk("issue_clr", 32'(o_clr), 32'd0);

        // CDB tag 1 bypasses in the same cycle
        step(0, 0, 0, 1, RS_ADD2, 0, 3'd2, 3'd2);
        chk("bypass_busy", 32'(o_ba), 32'd0);
        chk("bypass_cnt", 32'(o_cnt), 32'd1);
        idle(3'd2, 3'd0);
        chk("cdb_cleared", 32'(o_ba), 32'd0);
        chk("cdb_cnt", 32'(o_cnt), 32'd0);

        // issue beats a same-cycle CDB clear
        step(1, 3'd3, RS_ADD1, 0, 0, 0, 3'd3, 3'd0);
        step(1, 3'd3, RS_ADD2, 1, RS_ADD1, 0, 3'd3, 3'd0);
        idle(3'd3, 3'd0);
        chk("waw_busy", 32'(o_ba), 32'd1);
        chk("waw_qi", 32'(o_qa), 32'd1);
        step(1, 3'd5, RS_MUL1, 1, RS_MUL1, 0, 3'd3, 3'd5);
        idle(3'd5, 3'd3);
        chk("same_tag_busy", 32'(o_ba), 32'd1);
        chk("same_tag_qi", 32'(o_qa), 32'd2);

        // drain, then two entries on tag 2 clear together
        step(0, 0, 0, 1, RS_ADD2, 0, 3'd3, 3'd0);
        step(0, 0, 0, 1, RS_MUL1, 0, 3'd5, 3'd0);
        step(1, 3'd1, RS_MUL1, 0, 0, 0, 3'd1, 3'd4);
        step(1, 3'd4, RS_MUL1, 0, 0, 0, 3'd1, 3'd4);
        idle(3'd1, 3'd4);
        chk("multi_cnt_pre", 32'(o_cnt), 32'd2);
        step(0, 0, 0, 1, RS_MUL1, 0, 3'd1, 3'd4);
        idle(3'd1, 3'd4);
        chk("multi_a", 32'(o_ba), 32'd0);
        chk("multi_b", 32'(o_bb), 32'd0);
        chk("multi_cnt", 32'(o_cnt), 32'd0);

        // fill R1..R5, then flush wins over issue R6
        for (int r = 1; r <= 5; r++) begin
            step(1, 3'(r), 2'($urandom_range(0, 3)),
                 0, 0, 0, 3'(r), 3'd0);
        end
        idle(3'd1, 3'd5);
        chk("fill_cnt", 32'(o_cnt), 32'd5);
        step(1, 3'd6, RS_MUL2, 0, 0, 1, 3'd6, 3'd1);
        idle(3'd6, 3'd1);
        chk("flush_r6", 32'(o_ba), 32'd0);
        chk("flush_cnt", 32'(o_cnt), 32'd0);
        chk("flush_clr", 32'(o_clr), 32'd1);

        // async reset in the middle of an issue cycle
        step(1, 3'd0, RS_MUL2, 0, 0, 0, 3'd0, 3'd1);
        step(1, 3'd7, RS_ADD1, 0, 0, 0, 3'd0, 3'd7);
        @(negedge clk);
        bus.Issue_Rd  = 3'd6;
        bus.Rd_Addr_A = 3'd0;
        #1;
        chk("pre_rst_cnt", 32'(bus.Pending_Count), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(bus.Pending_Count), 32'd0);
        chk("mid_rst_clr", 32'(bus.All_Clear), 32'd1);
        chk("mid_rst_busy", 32'(bus.Busy_A), 32'd0);
        m_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.Issue_En = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 40) == 0),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
